mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit that drives the single-port word RAM (mem_addr/mem_we/mem_wdata/mem_rdata) on behalf of the core.
- Accepts byte, halfword and word requests over a valid/ready handshake and returns a single-cycle response pulse.
- Performs sign/zero extension on loads.
- Implements sub-word stores by read-modify-write of the containing word.
- Sits between the core pipeline and the ram instance.

Parameters:
- MEM_SIZE, 128, RAM depth in 32-bit words; valid byte addresses are 0 .. MEM_SIZE*4-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned, out of range, or had size 3; qualified by resp_valid.
- mem_addr  output  32  word-aligned byte address to RAM; bits [1:0] always 0.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data; valid one clock edge after mem_addr is presented with mem_we = 0.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. While reset is high the FSM is held in IDLE and all registered outputs are 0. req_ready = (state == IDLE) && !reset.
- Reset values: resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- FSM states: IDLE, READ, WRITE, RESP.
- Accept: at a rising edge with req_valid && req_ready, latch we, size, unsigned, addr and wdata. No other request is accepted until the FSM returns to IDLE.
- Error check at accept. An error is any of:
  - size == 3
  - size == 1 with addr[0] != 0
  - size == 2 with addr[1:0] != 0
  - addr >= MEM_SIZE*4
- On error: IDLE -> RESP with err = 1. No RAM access; mem_we stays 0.
- Load: IDLE -> READ -> RESP.
  - READ drives mem_addr = {addr[31:2], 2'b00} with mem_we = 0.
  - At the edge leaving READ, extract the addressed lane from mem_rdata and register it into resp_rdata: byte = addr[1:0]*8 offset; half = addr[1]*16 offset.
  - Extend the lane to 32 bits per the latched unsigned flag.
- Word store: IDLE -> WRITE -> RESP. WRITE drives mem_we = 1, mem_wdata = wdata.
- Sub-word store: IDLE -> READ -> WRITE -> RESP.
  - WRITE drives mem_wdata = mem_rdata with only the addressed byte/half lane replaced by the low bits of wdata.
  - All other lanes are preserved bit-exact.
- mem_we is asserted only in WRITE, for exactly one cycle per store.
- mem_addr holds the latched word address in READ and WRITE. It is 0 in IDLE and RESP.
- RESP: resp_valid = 1 for exactly one cycle, then -> IDLE. No backpressure on the response.
- Latency, counted in rising edges after the accept edge until resp_valid is high:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 3
- Throughput: a new request can be accepted on the edge that leaves RESP's following IDLE cycle. req_ready is high only in IDLE.
- Reset asserted mid-operation: immediately return to IDLE with outputs cleared. An in-flight store whose WRITE edge has not occurred is dropped; no partial write.
- req_valid deasserting while req_ready = 0 has no effect; inputs are only sampled at accept.

Test Plan:
- Word store 0x12345678 to addr 0x0, then word load from 0x0 -> mem_we pulses once; load resp_rdata = 0x12345678, resp_err = 0, resp_valid 3 edges after accept.
- Byte store 0xAB to addr 0x2 over word 0x12345678, then word load -> 0x12AB5678. Byte load from 0x2 with unsigned = 0 -> 0xFFFFFFAB; with unsigned = 1 -> 0x000000AB.
- Half store 0x8001 to addr 0x6 over word 0x00000000, then half load from 0x6: signed -> 0xFFFF8001; unsigned -> 0x00008001. Word at 0x4 reads 0x80010000.
- Misaligned word load at 0x2, half store at 0x1, size = 3, and addr = MEM_SIZE*4 (0x200) -> resp_err = 1 one edge after accept, resp_rdata = 0, mem_we never asserted, RAM contents unchanged.
- Back-to-back: req_valid held high with 4 queued requests -> req_ready low outside IDLE, each request accepted exactly once, responses in order, exactly one resp_valid pulse per request.
- Assert reset during the READ state of a byte store to 0x0 -> FSM in IDLE, resp_valid = 0, word 0x0 unchanged. After reset release req_ready = 1 and the next load succeeds.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit on the initiator side. It drives a single-port word RAM
//   for the core. Requests can be byte, halfword or word sized and arrive
//   over a valid/ready handshake. Each request gets a single-cycle response
//   pulse. Loads are sign- or zero-extended. Sub-word stores read the
//   containing word, modify it and write it back.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_size              0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid            one-cycle response pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              misaligned / out of range / illegal size
//   mem_addr              word-aligned RAM address (0 when idle)
//   mem_we                RAM write enable (one cycle per store)
//   mem_wdata             RAM write data
//   mem_rdata             RAM read data, one edge after mem_addr
module mem_access_unit #(
  parameter int MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        read_wait;
  logic        accept;
  logic        req_err;
  logic [4:0]  shamt;
  logic [31:0] lane;
  logic [31:0] load_value;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Request legality, judged on the live request at the accept edge
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)                          req_err = 1'b1;
    if (req_size == 2'd1 && req_addr[0])           req_err = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr >= ADDR_LIMIT)                    req_err = 1'b1;
  end

  // Lane handling. Alignment is checked at accept, so the byte offset times
  // eight serves both byte and half lanes.
  assign shamt     = {lat_addr[1:0], 3'b000};
  assign lane      = mem_rdata >> shamt;
  assign lane_mask = ((lat_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
  assign merged    = (mem_rdata & ~lane_mask) | ((lat_wdata << shamt) & lane_mask);

  always_comb begin
    load_value = mem_rdata;
    case (lat_size)
      2'd0:    load_value = lat_unsigned ? {24'h0, lane[7:0]}
                                         : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_value = lat_unsigned ? {16'h0, lane[15:0]}
                                         : {{16{lane[15]}}, lane[15:0]};
      default: load_value = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The RAM returns data one edge after the address. A load therefore waits
  // one extra READ cycle so it can capture the lane as READ is left. A
  // sub-word store goes straight on to WRITE. There the read word is already
  // on mem_rdata and can be merged combinationally.
  always_comb begin
    state_next = state;
    mem_addr   = 32'h0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                         state_next = RESP;
          else if (req_we && req_size == 2'd2) state_next = WRITE;
          else                                 state_next = READ;
        end
      end
      READ: begin
        mem_addr = {lat_addr[31:2], 2'b00};
        if (lat_we)         state_next = WRITE;
        else if (read_wait) state_next = RESP;
      end
      WRITE: begin
        mem_addr   = {lat_addr[31:2], 2'b00};
        mem_we     = 1'b1;
        mem_wdata  = (lat_size == 2'd2) ? lat_wdata : merged;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and the registered response fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we       <= 1'b0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      read_wait    <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= 1'b0;
    end else if (accept) begin
      lat_we       <= req_we;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
      read_wait    <= 1'b0;
      resp_rdata   <= 32'h0;
      resp_err     <= req_err;
    end else if (state == READ) begin
      read_wait <= 1'b1;
      if (!lat_we && read_wait) resp_rdata <= load_value;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Bench for mem_access_unit. It holds a behavioural RAM with one edge of
//   read latency. Requests come from a table of hand-derived vectors, with a
//   few extra sequences for back-to-back requests and reset mid-operation.
//   Expected responses go into a queue when a request is accepted. They are
//   popped and compared when resp_valid is seen.
module tb_mem_access_unit;

  localparam int MEM_SIZE = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        ram_clear;
  logic [31:0] ram [0:MEM_SIZE-1];

  int assert_count = 0;
  int fail_count   = 0;
  int cycle        = 0;
  int we_count     = 0;
  int resp_count   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          acc_cycle;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[24];

  mem_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural RAM: synchronous write and read-old-data synchronous read
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] <= 32'h0;
    end else if (mem_we) begin
      ram[mem_addr[8:2]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[8:2]];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Response monitor: pops the scoreboard and checks data, error flag,
  // latency and the number of RAM writes since the previous response
  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      checkOutput("mem_addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
    end
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        checkOutput("resp_unexpected", {31'h0, resp_valid}, 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        checkOutput("resp_rdata", resp_rdata, e.exp_rdata);
        checkOutput("resp_err", {31'h0, resp_err}, {31'h0, e.exp_err});
        checkOutput("resp_latency", 32'(cycle - e.acc_cycle + 1), 32'(e.exp_lat));
        checkOutput("mem_we_pulses", 32'(we_count), 32'(e.exp_we));
      end
      we_count = 0;
    end
  end

  // Offers one request and waits (bounded) for it to be accepted. The
  // expected response is queued on the accept edge when expect_resp is set.
  task automatic applyStimulus(input vec_t v, input bit hold_valid, input bit expect_resp);
    sb_t e;
    bit  ready_seen;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    ready_seen   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      if (req_ready) begin
        ready_seen = 1'b1;
        break;
      end
    end
    if (!ready_seen) begin
      checkOutput("req_ready_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (expect_resp) begin
      e.exp_rdata = v.exp_rdata;
      e.exp_err   = v.exp_err;
      e.exp_lat   = v.exp_lat;
      e.exp_we    = (v.we && !v.exp_err) ? 1 : 0;
      e.acc_cycle = cycle;
      sb.push_back(e);
    end
    if (!hold_valid) req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checkOutput("resp_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   resp_before;

    //          we size uns addr          wdata          exp_rdata      err lat
    vecs[0]  = '{1, 2, 0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0, 2};
    vecs[1]  = '{0, 2, 0, 32'h0000_0000, 32'h0,         32'h1234_5678, 0, 3};
    vecs[2]  = '{1, 0, 0, 32'h0000_0002, 32'h0000_00AB, 32'h0000_0000, 0, 3};
    vecs[3]  = '{0, 2, 0, 32'h0000_0000, 32'h0,         32'h12AB_5678, 0, 3};
    vecs[4]  = '{0, 0, 0, 32'h0000_0002, 32'h0,         32'hFFFF_FFAB, 0, 3};
    vecs[5]  = '{0, 0, 1, 32'h0000_0002, 32'h0,         32'h0000_00AB, 0, 3};
    vecs[6]  = '{1, 1, 0, 32'h0000_0006, 32'h0000_8001, 32'h0000_0000, 0, 3};
    vecs[7]  = '{0, 1, 0, 32'h0000_0006, 32'h0,         32'hFFFF_8001, 0, 3};
    vecs[8]  = '{0, 1, 1, 32'h0000_0006, 32'h0,         32'h0000_8001, 0, 3};
    vecs[9]  = '{0, 2, 0, 32'h0000_0004, 32'h0,         32'h8001_0000, 0, 3};
    vecs[10] = '{0, 2, 0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1, 1};
    vecs[11] = '{1, 1, 0, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_0000, 1, 1};
    vecs[12] = '{0, 3, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1, 1};
    vecs[13] = '{0, 2, 0, 32'h0000_0200, 32'h0,         32'h0000_0000, 1, 1};
    vecs[14] = '{1, 0, 0, 32'h0000_0203, 32'h0000_0055, 32'h0000_0000, 1, 1};
    vecs[15] = '{0, 2, 0, 32'h0000_0000, 32'h0,         32'h12AB_5678, 0, 3};
    vecs[16] = '{0, 0, 0, 32'h0000_0003, 32'h0,         32'h0000_0012, 0, 3};
    vecs[17] = '{0, 1, 0, 32'h0000_0002, 32'h0,         32'h0000_12AB, 0, 3};
    vecs[18] = '{1, 0, 0, 32'h0000_0001, 32'h0000_5A3C, 32'h0000_0000, 0, 3};
    vecs[19] = '{0, 2, 0, 32'h0000_0000, 32'h0,         32'h12AB_3C78, 0, 3};
    vecs[20] = '{1, 2, 0, 32'h0000_01FC, 32'hDEAD_BEEF, 32'h0000_0000, 0, 2};
    vecs[21] = '{0, 0, 1, 32'h0000_01FF, 32'h0,         32'h0000_00DE, 0, 3};
    vecs[22] = '{0, 1, 0, 32'h0000_01FC, 32'h0,         32'hFFFF_BEEF, 0, 3};
    vecs[23] = '{0, 1, 1, 32'h0000_01FE, 32'h0,         32'h0000_DEAD, 0, 3};

    reset        = 1'b1;
    ram_clear    = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset_resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("reset_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    ram_clear = 1'b0;
    reset     = 1'b0;
    #1;
    checkOutput("post_reset_req_ready", {31'h0, req_ready}, 32'h1);

    $display("[TB] Table-driven vectors");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i], 1'b0, 1'b1);
      waitDrain();
    end
    checkOutput("ram_after_table", ram[0], 32'h12AB_3C78);

    $display("[TB] Reset during READ of a byte store");
    v = '{1, 0, 0, 32'h0000_0000, 32'h0000_00EE, 32'h0, 0, 3};
    applyStimulus(v, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("midreset_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("midreset_mem_addr", mem_addr, 32'h0);
    checkOutput("midreset_req_ready", {31'h0, req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_release_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("midreset_ram_word0", ram[0], 32'h12AB_3C78);
    v = '{0, 2, 0, 32'h0000_0000, 32'h0, 32'h12AB_3C78, 0, 3};
    applyStimulus(v, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] Back-to-back requests with req_valid held high");
    resp_before = resp_count;
    v = '{1, 2, 0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0, 2};
    applyStimulus(v, 1'b1, 1'b1);
    checkOutput("b2b_ready_low", {31'h0, req_ready}, 32'h0);
    v = '{0, 2, 0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 3};
    applyStimulus(v, 1'b1, 1'b1);
    v = '{0, 0, 0, 32'h0000_0013, 32'h0, 32'hFFFF_FFCA, 0, 3};
    applyStimulus(v, 1'b1, 1'b1);
    v = '{0, 2, 0, 32'h0000_0011, 32'h0, 32'h0000_0000, 1, 1};
    applyStimulus(v, 1'b0, 1'b1);
    waitDrain();
    repeat (4) @(negedge clk);
    checkOutput("b2b_resp_count", 32'(resp_count - resp_before), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
